stamp_capture_arbiter: RTL and testbench
========================================

# stamp_capture_arbiter

Shares the free-running `stamp_counter` value between several requesters, typically one per 10G port, that each need a timestamp at a single-cycle event such as start-of-frame. Each request latches the counter value in the cycle it arrives, so arbitration delay never skews the stamp. A round-robin arbiter then serializes the latched stamps onto one valid/ready output stream for the downstream stamp logger. The block sits beside `stamp_counter` inside the timestamp pcore, in the same clock domain.

## Interface
- `NUM_PORTS`, default 4: number of requesters, range 2..8.
- `TIMESTAMP_WIDTH`, default 64: width of the counter value and of the captured stamp.
- `PORT_ID_WIDTH`, default 2: width of the source port index; must equal clog2(`NUM_PORTS`).

- `axi_aclk`  in  1  Single clock for the whole block.
- `axi_resetn`  in  1  Reset, asynchronous, active-low.
- `stamp_counter`  in  TIMESTAMP_WIDTH  Free-running counter value.
- `cap_req`  in  NUM_PORTS  Per-port capture request, one-cycle pulse.
- `cap_busy`  out  NUM_PORTS  Per-port holding slot is occupied.
- `cap_drop`  out  NUM_PORTS  One-cycle pulse when a request is lost.
- `m_valid`  out  1  Output stamp valid.
- `m_ready`  in  1  Downstream accepts the output stamp.
- `m_stamp`  out  TIMESTAMP_WIDTH  Captured stamp.
- `m_port`  out  PORT_ID_WIDTH  Index of the port that produced the stamp.
- `drop_clr`  in  1  Clears all drop counters. Present only with `STAMP_CAPTURE_DROP_CNT_EN`.
- `drop_cnt`  out  NUM_PORTS*16  Per-port drop counters; port i occupies bits [16i+15:16i]. Present only with `STAMP_CAPTURE_DROP_CNT_EN`.

## Operation
- **Holding slots.** Each port has one slot, a valid bit plus a stamp register.
  - If `cap_req[i]` arrives and slot i is empty, or is being granted in the same cycle, slot i takes the `stamp_counter` value of that cycle. `cap_busy[i]` rises the next cycle.
  - If `cap_req[i]` arrives while slot i is full and not being granted, the request is discarded, the slot is left unchanged, and `cap_drop[i]` pulses the next cycle.
- **Output register.** `m_valid`, `m_stamp` and `m_port` stay stable while `m_valid=1` and `m_ready=0`. A transfer occurs when `m_valid & m_ready`.
- **Load condition.** The output register loads when `!m_valid | m_ready` and at least one slot is valid. It loads the granted slot's stamp and index, and that slot clears in the same edge. If no slot is valid and `m_ready=1`, `m_valid` drops to 0.
- **Round-robin grant.** The grant goes to the first valid slot searching upward from `last_grant+1`, modulo `NUM_PORTS`. `last_grant` updates only on a load. After reset `last_grant` is NUM_PORTS-1, so port 0 has first priority.
- **Stamp values.** No arithmetic is performed on stamps; the counter value passes through bit-exact. Counter wrap-around is the consumer's concern.
- **Reset.** Asserting `axi_resetn` in the middle of operation discards all pending slots and any stamp in the output register.

## Timing
- **Reset values.** `m_valid=0`, `m_stamp=0`, `m_port=0`, `cap_busy=0`, `cap_drop=0`, `drop_cnt=0`, `last_grant=NUM_PORTS-1`.
- **Latency.** Minimum latency from `cap_req` in cycle t to `m_valid` is 2 cycles: the slot is valid at t+1 and the output at t+2.
- **Throughput.** With `m_ready` held high, the block sustains one stamp per cycle.
- **Worst-case wait.** With `m_ready` held high, a slot is granted within `NUM_PORTS` cycles of becoming valid.
- **Simultaneous requests.** All simultaneous requests capture the identical counter value. They are emitted in round-robin order.

## Configuration
- **`STAMP_CAPTURE_DROP_CNT_EN` defined:**
  - Each port has a 16-bit drop counter that increments with `cap_drop[i]` and saturates at 0xFFFF.
  - A `drop_clr` pulse zeros all counters. If `drop_clr` and a drop coincide, the counter ends at 0.
  - The `drop_clr` and `drop_cnt` ports exist.
- **Undefined:** the counters, `drop_clr` and `drop_cnt` are absent. The `cap_drop` pulses remain.

## Structure
- **Package `stamp_capture_pkg`:**
  - Default `NUM_PORTS`.
  - `DROP_CNT_WIDTH=16`.
  - `DROP_CNT_MAX=16'hFFFF`.
  - A port-index typedef derived from `PORT_ID_WIDTH`.
- **Sub-module `rr_arbiter`:** takes the request vector, the advance strobe and `last_grant`, and returns a one-hot grant plus the encoded index. It is parameterized by `NUM_PORTS` and is reusable elsewhere in the design.

## Test plan
- **Single request:** `stamp_counter=0x1000` with `cap_req=0001` in cycle t and `m_ready=1` -> `m_valid` in cycle t+2 with `m_stamp=0x1000`, `m_port=0`.
- **Simultaneous requests:** all 4 ports request at `stamp_counter=0x55` after reset with `m_ready=1` -> 4 consecutive outputs, ports 0,1,2,3, all with stamp 0x55.
- **Backpressure:** `m_ready=0` for 10 cycles with one pending stamp -> outputs stay stable; then `m_ready=1` -> exactly one transfer, no duplicate.
- **Drop:** port 2 requests twice, 3 cycles apart, while `m_ready=0` and the output is full -> `cap_drop[2]` pulses once; `drop_cnt` for port 2 reads 1 (macro on); the second stamp is lost.
- **Grant and request in the same cycle:** `cap_req[1]` coincides with the grant of slot 1 -> the new stamp is captured and there is no drop.
- **Reset mid-operation:** `axi_resetn` is asserted with 3 slots and the output full -> all outputs return to reset values immediately, and the first grant after release goes to port 0.

Source files
------------

// File: rtl/stamp_capture_pkg.sv
// Shared constants and types for the timestamp capture arbiter.
// Drop counters are built only when STAMP_CAPTURE_DROP_CNT_EN is defined.
package stamp_capture_pkg;

    localparam int NUM_PORTS_DEFAULT     = 4;
    localparam int PORT_ID_WIDTH_DEFAULT = $clog2(NUM_PORTS_DEFAULT);

    localparam int                        DROP_CNT_WIDTH = 16;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX   = 16'hFFFF;

    typedef logic [PORT_ID_WIDTH_DEFAULT-1:0] port_idx_t;

endpackage

// File: rtl/stamp_capture_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester searching upward from last_grant+1.
// The one-hot grant is asserted only when adv is high; the index and gnt_any are always valid.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 adv,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 gnt_any
);

    function automatic logic [IDX_WIDTH-1:0] wrap_idx(input logic [IDX_WIDTH-1:0] base,
                                                      input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return IDX_WIDTH'(s);
    endfunction

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        // Offset NUM_PORTS wraps back to last_grant itself, so it has lowest priority.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!gnt_any && req[wrap_idx(last_grant, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(last_grant, k);
            end
        end
        if (gnt_any && adv) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/stamp_capture_arbiter.sv
// Latches stamp_counter per port on cap_req and serializes the stamps round-robin onto one stream.
// Optional per-port saturating drop counters are enabled by STAMP_CAPTURE_DROP_CNT_EN.
module stamp_capture_arbiter
    import stamp_capture_pkg::*;
#(
    parameter int NUM_PORTS       = NUM_PORTS_DEFAULT,
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int PORT_ID_WIDTH   = PORT_ID_WIDTH_DEFAULT
) (
    input  logic                       axi_aclk,
    input  logic                       axi_resetn,
    input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
    input  logic [NUM_PORTS-1:0]       cap_req,
    output logic [NUM_PORTS-1:0]       cap_busy,
    output logic [NUM_PORTS-1:0]       cap_drop,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [TIMESTAMP_WIDTH-1:0] m_stamp,
    output logic [PORT_ID_WIDTH-1:0]   m_port
`ifdef STAMP_CAPTURE_DROP_CNT_EN
    ,
    input  logic                       drop_clr,
    output logic [NUM_PORTS*DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

    // Handshake: a stamp transfers on any edge where m_valid & m_ready; while m_valid is
    // high and m_ready low, m_valid/m_stamp/m_port hold their values unchanged.

    logic [NUM_PORTS-1:0]       slot_v;
    logic [TIMESTAMP_WIDTH-1:0] slot_stamp [NUM_PORTS];
    logic [NUM_PORTS-1:0]       gnt;
    logic [PORT_ID_WIDTH-1:0]   gnt_idx;
    logic [PORT_ID_WIDTH-1:0]   last_grant;
    logic                       gnt_any;
    logic                       load;
    logic [NUM_PORTS-1:0]       take;
    logic [NUM_PORTS-1:0]       drop_now;

    assign load = (~m_valid | m_ready) & gnt_any;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (PORT_ID_WIDTH)
    ) u_rr_arbiter (
        .req        (slot_v),
        .adv        (load),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    // A slot being drained this edge can accept a fresh capture without a drop.
    assign take     = cap_req & (~slot_v | gnt);
    assign drop_now = cap_req & slot_v & ~gnt;
    assign cap_busy = slot_v;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            slot_v   <= '0;
            cap_drop <= '0;
            for (int i = 0; i < NUM_PORTS; i++) slot_stamp[i] <= '0;
        end else begin
            cap_drop <= drop_now;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (take[i]) begin
                    slot_v[i]     <= 1'b1;
                    slot_stamp[i] <= stamp_counter;
                end else if (gnt[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            m_valid    <= 1'b0;
            m_stamp    <= '0;
            m_port     <= '0;
            last_grant <= PORT_ID_WIDTH'(NUM_PORTS - 1);
        end else if (load) begin
            m_valid    <= 1'b1;
            m_stamp    <= slot_stamp[gnt_idx];
            m_port     <= gnt_idx;
            last_grant <= gnt_idx;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef STAMP_CAPTURE_DROP_CNT_EN
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_drop_cnt
        logic [DROP_CNT_WIDTH-1:0] cnt;

        always_ff @(posedge axi_aclk or negedge axi_resetn) begin
            if (!axi_resetn) begin
                cnt <= '0;
            end else if (drop_clr) begin
                cnt <= '0;
            end else if (cap_drop[g] && (cnt != DROP_CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign drop_cnt[g*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = cnt;
    end
`else
    // Without counters, losses are visible only through the cap_drop pulses.
`endif

endmodule

// File: tb/tb_stamp_capture_arbiter.sv
// Directed bench for stamp_capture_arbiter: capture latency, round-robin order, backpressure,
// drops, same-cycle grant/capture and mid-operation reset, with a stamp scoreboard.
module tb_stamp_capture_arbiter;
    import stamp_capture_pkg::*;

    localparam int NP = 4;
    localparam int TW = 64;
    localparam int PW = 2;

    logic            axi_aclk;
    logic            axi_resetn;
    logic [TW-1:0]   stamp_counter;
    logic [NP-1:0]   cap_req;
    logic [NP-1:0]   cap_busy;
    logic [NP-1:0]   cap_drop;
    logic            m_valid;
    logic            m_ready;
    logic [TW-1:0]   m_stamp;
    logic [PW-1:0]   m_port;
`ifdef STAMP_CAPTURE_DROP_CNT_EN
    logic            drop_clr;
    logic [NP*16-1:0] drop_cnt;
`endif

    stamp_capture_arbiter #(
        .NUM_PORTS       (NP),
        .TIMESTAMP_WIDTH (TW),
        .PORT_ID_WIDTH   (PW)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .stamp_counter (stamp_counter),
        .cap_req       (cap_req),
        .cap_busy      (cap_busy),
        .cap_drop      (cap_drop),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_stamp       (m_stamp),
        .m_port        (m_port)
`ifdef STAMP_CAPTURE_DROP_CNT_EN
        ,
        .drop_clr      (drop_clr),
        .drop_cnt      (drop_cnt)
`endif
    );

    // Clock and reset
    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    int n_cmp  = 0;
    int n_err  = 0;
    int n_xfer = 0;
    logic [PW+TW-1:0] exp_q[$];
    logic [PW+TW-1:0] sb_e;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1ns after a rising edge and are consumed by the next rising edge.
    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic do_reset();
        axi_resetn    = 1'b0;
        cap_req       = '0;
        m_ready       = 1'b0;
        stamp_counter = '0;
`ifdef STAMP_CAPTURE_DROP_CNT_EN
        drop_clr      = 1'b0;
`endif
        repeat (3) step();
        axi_resetn = 1'b1;
    endtask

    task automatic request(input logic [NP-1:0] mask, input logic [TW-1:0] stamp);
        cap_req       = mask;
        stamp_counter = stamp;
        step();
        cap_req       = '0;
        stamp_counter = ~stamp;
    endtask

    task automatic push_exp(input logic [PW-1:0] port, input logic [TW-1:0] stamp);
        exp_q.push_back({port, stamp});
    endtask

    // Scoreboard: on the falling edge, a valid & ready pair will transfer at the next rise.
    always @(negedge axi_aclk) begin
        if (axi_resetn && m_valid && m_ready) begin
            n_xfer++;
            check_val("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check_val("sb_port", 64'(m_port), 64'(sb_e[PW+TW-1:TW]));
                check_val("sb_stamp", m_stamp, sb_e[TW-1:0]);
            end
        end
    end

    int xfer_before;
    port_idx_t exp_port;

    initial begin
        do_reset();
        check_val("rst_m_valid", 64'(m_valid), 64'd0);
        check_val("rst_m_stamp", m_stamp, 64'd0);
        check_val("rst_m_port", 64'(m_port), 64'd0);
        check_val("rst_cap_busy", 64'(cap_busy), 64'd0);
        check_val("rst_cap_drop", 64'(cap_drop), 64'd0);
`ifdef STAMP_CAPTURE_DROP_CNT_EN
        check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

        // Single request: valid two cycles after the request edge.
        m_ready = 1'b1;
        push_exp(2'd0, 64'h1000);
        request(4'b0001, 64'h1000);
        check_val("single_busy_t1", 64'(cap_busy), 64'b0001);
        check_val("single_valid_t1", 64'(m_valid), 64'd0);
        step();
        check_val("single_valid_t2", 64'(m_valid), 64'd1);
        check_val("single_stamp", m_stamp, 64'h1000);
        check_val("single_port", 64'(m_port), 64'd0);
        check_val("single_busy_t2", 64'(cap_busy), 64'd0);
        step();
        check_val("single_idle", 64'(m_valid), 64'd0);

        // Simultaneous requests after reset: ports 0..3 back to back, same stamp.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < NP; i++) push_exp(PW'(i), 64'h55);
        request(4'b1111, 64'h55);
        for (int i = 0; i < NP; i++) begin
            step();
            exp_port = port_idx_t'(i);
            check_val("simul_valid", 64'(m_valid), 64'd1);
            check_val("simul_port", 64'(m_port), 64'(exp_port));
            check_val("simul_stamp", m_stamp, 64'h55);
        end
        step();
        check_val("simul_idle", 64'(m_valid), 64'd0);

        // Backpressure: output holds for 10 cycles, then exactly one transfer.
        m_ready = 1'b0;
        push_exp(2'd3, 64'h3333);
        request(4'b1000, 64'h3333);
        step();
        check_val("bp_valid", 64'(m_valid), 64'd1);
        check_val("bp_port", 64'(m_port), 64'd3);
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("bp_hold_valid", 64'(m_valid), 64'd1);
            check_val("bp_hold_stamp", m_stamp, 64'h3333);
            check_val("bp_hold_port", 64'(m_port), 64'd3);
        end
        xfer_before = n_xfer;
        m_ready = 1'b1;
        step();
        check_val("bp_released", 64'(m_valid), 64'd0);
        check_val("bp_one_xfer", 64'(n_xfer - xfer_before), 64'd1);

        // Drop: port 2 requests twice, 3 cycles apart, with output full and stalled.
        m_ready = 1'b0;
        push_exp(2'd1, 64'hA1);
        request(4'b0010, 64'hA1);
        step();
        check_val("drop_out_full", 64'(m_valid), 64'd1);
        push_exp(2'd2, 64'h200);
        request(4'b0100, 64'h200);
        check_val("drop_busy", 64'(cap_busy), 64'b0100);
        check_val("drop_none_yet", 64'(cap_drop), 64'd0);
        step();
        step();
        request(4'b0100, 64'h203);
        check_val("drop_pulse", 64'(cap_drop), 64'b0100);
        check_val("drop_slot_kept", 64'(cap_busy), 64'b0100);
        step();
        check_val("drop_pulse_end", 64'(cap_drop), 64'd0);
`ifdef STAMP_CAPTURE_DROP_CNT_EN
        check_val("drop_cnt_p2", 64'(drop_cnt[47:32]), 64'd1);
        check_val("drop_cnt_p1", 64'(drop_cnt[31:16]), 64'd0);
`endif
        m_ready = 1'b1;
        step();
        check_val("drop_next_port", 64'(m_port), 64'd2);
        check_val("drop_next_stamp", m_stamp, 64'h200);
        step();
        check_val("drop_drained", 64'(m_valid), 64'd0);

        // Request coinciding with the grant of the same slot is captured, not dropped.
        push_exp(2'd1, 64'h111);
        push_exp(2'd1, 64'h112);
        request(4'b0010, 64'h111);
        request(4'b0010, 64'h112);
        check_val("same_first_stamp", m_stamp, 64'h111);
        check_val("same_busy", 64'(cap_busy), 64'b0010);
        check_val("same_no_drop_t0", 64'(cap_drop), 64'd0);
        step();
        check_val("same_no_drop", 64'(cap_drop), 64'd0);
        check_val("same_second_stamp", m_stamp, 64'h112);
        check_val("same_second_port", 64'(m_port), 64'd1);
        step();
        check_val("same_idle", 64'(m_valid), 64'd0);

`ifdef STAMP_CAPTURE_DROP_CNT_EN
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        check_val("drop_clr", 64'(drop_cnt), 64'd0);
`endif

        // Reset mid-operation with three slots pending and the output full.
        m_ready = 1'b0;
        request(4'b1111, 64'h77);
        step();
        check_val("mid_busy", 64'(cap_busy), 64'b1011);
        check_val("mid_port", 64'(m_port), 64'd2);
        axi_resetn = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(m_valid), 64'd0);
        check_val("mid_rst_stamp", m_stamp, 64'd0);
        check_val("mid_rst_port", 64'(m_port), 64'd0);
        check_val("mid_rst_busy", 64'(cap_busy), 64'd0);
        step();
        step();
        axi_resetn = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < NP; i++) push_exp(PW'(i), 64'h99);
        request(4'b1111, 64'h99);
        step();
        check_val("post_rst_port", 64'(m_port), 64'd0);
        check_val("post_rst_stamp", m_stamp, 64'h99);
        repeat (6) step();

        check_val("sb_drained", 64'(exp_q.size()), 64'd0);
        check_val("total_xfers", 64'(n_xfer), 64'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
